// File: rtl/seq_mul_pkg.sv
// Shared types and default sizing for the sequential multiplier controller.
package seq_mul_pkg;

  localparam int SEQ_MUL_W        = 2;
  localparam int SEQ_MUL_MAX_ITER = 2 ** SEQ_MUL_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ADD  = 3'd2,
    CAPT = 3'd3,
    DONE = 3'd4
  } mul_state_t;

  // Result record as seen by the consumer at the default operand width.
  typedef struct packed {
    logic [2*SEQ_MUL_W-1:0] data;
    logic [SEQ_MUL_W:0]     cycles;
    logic                   err;
  } mul_resp_t;

endpackage

// File: rtl/seq_mul_ctrl_if.sv
// Request/response handshake bundle between a requester and the multiplier controller.
interface seq_mul_ctrl_if import seq_mul_pkg::*; #(
  parameter int W = SEQ_MUL_W
);
  logic           req_valid;
  logic           req_ready;
  logic [W-1:0]   req_a;
  logic [W-1:0]   req_b;
  logic           res_valid;
  logic           res_ready;
  logic [2*W-1:0] res_data;
  logic [W:0]     res_cycles;
  logic           res_err;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_cycles, res_err
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_cycles, res_err
  );
endinterface

// File: rtl/seq_mul_watchdog.sv
// Add-cycle counter with terminal-count compare; expired flags the last permitted add.
module seq_mul_watchdog import seq_mul_pkg::*; #(
  parameter int W        = SEQ_MUL_W,
  parameter int MAX_ITER = 2 ** W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [W:0] iter,
  output logic       expired
);
  localparam logic [W:0] ITER_MAX = (W+1)'(MAX_ITER);
  localparam logic [W:0] ITER_TC  = (W+1)'(MAX_ITER - 1);

  logic [W:0] iter_q, iter_d;

  // Clear wins over increment; the count holds once it reaches MAX_ITER.
  always_comb begin
    iter_d = iter_q;
    if (clr)
      iter_d = '0;
    else if (inc && (iter_q != ITER_MAX))
      iter_d = iter_q + (W+1)'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) iter_q <= '0;
    else        iter_q <= iter_d;
  end

  assign iter    = iter_q;
  assign expired = (iter_q == ITER_TC);
endmodule

// File: rtl/seq_mul_ctrl.sv
// Controller for the repeated-addition multiplier datapath.
//
// state | meaning
// IDLE  | ready for operands, accumulator held clear
// LOAD  | load A register and B counter (one cycle)
// ADD   | accumulate A and decrement B while zero is low
// CAPT  | latch the datapath product
// DONE  | present the result until the consumer takes it
module seq_mul_ctrl import seq_mul_pkg::*; #(
  parameter int W        = SEQ_MUL_W,
  parameter int MAX_ITER = 2 ** W
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_mul_ctrl_if.slave  bus,
  input  logic           abort,
  output logic [W-1:0]   dp_a,
  output logic [W-1:0]   dp_b,
  output logic           loadA,
  output logic           loadB,
  output logic           decB,
  output logic           loadF,
  output logic           clear,
  input  logic           zero,
  input  logic [2*W-1:0] dp_product
);
  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_LOAD = LOAD;
  localparam logic [2:0] S_ADD  = ADD;
  localparam logic [2:0] S_CAPT = CAPT;
  localparam logic [2:0] S_DONE = DONE;

  logic [2:0]     state_q, state_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic [2*W-1:0] res_data_q, res_data_d;
  logic [W:0]     res_cycles_q, res_cycles_d;
  logic           res_err_q, res_err_d;
  logic [W:0]     iter;
  logic           expired;

  seq_mul_watchdog #(.W(W), .MAX_ITER(MAX_ITER)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == S_LOAD),
    .inc     (decB),
    .iter    (iter),
    .expired (expired)
  );

  // Next state, operand latch and result register updates.
  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    res_data_d   = res_data_q;
    res_cycles_d = res_cycles_q;
    res_err_d    = res_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_a_d = bus.req_a;
          op_b_d = bus.req_b;
          if ((bus.req_a == '0) || (bus.req_b == '0)) begin
            // Trivial product: skip the datapath entirely.
            state_d      = S_DONE;
            res_data_d   = '0;
            res_cycles_d = '0;
            res_err_d    = 1'b0;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: state_d = abort ? S_IDLE : S_ADD;
      S_ADD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (zero) begin
          state_d = S_CAPT;
        end else if (expired) begin
          state_d      = S_DONE;
          res_data_d   = '0;
          res_cycles_d = (W+1)'(MAX_ITER);
          res_err_d    = 1'b1;
        end
      end
      S_CAPT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d      = S_DONE;
          res_data_d   = dp_product;
          res_cycles_d = iter;
          res_err_d    = 1'b0;
        end
      end
      S_DONE:  if (bus.res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      res_data_q   <= '0;
      res_cycles_q <= '0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      res_data_q   <= res_data_d;
      res_cycles_q <= res_cycles_d;
      res_err_q    <= res_err_d;
    end
  end

  // Strobes decode from the state register; decB/loadF also follow zero.
  always_comb begin
    clear = (state_q == S_IDLE);
    loadA = (state_q == S_LOAD);
    loadB = (state_q == S_LOAD);
    decB  = (state_q == S_ADD) && !zero;
    loadF = (state_q == S_ADD) && !zero;
  end

  assign dp_a           = op_a_q;
  assign dp_b           = op_b_q;
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.res_valid  = (state_q == S_DONE);
  assign bus.res_data   = res_data_q;
  assign bus.res_cycles = res_cycles_q;
  assign bus.res_err    = res_err_q;
endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Bench for seq_mul_ctrl with a behavioural repeated-addition datapath attached.
module tb_seq_mul_ctrl;
  import seq_mul_pkg::*;

  localparam int W        = SEQ_MUL_W;
  localparam int MAX_ITER = SEQ_MUL_MAX_ITER;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           abort;
  logic [W-1:0]   dp_a, dp_b;
  logic           loadA, loadB, decB, loadF, clear;
  logic           zero;
  logic [2*W-1:0] dp_product;
  logic           force_zero_low;

  int checks = 0;
  int errors = 0;
  int n_decb, n_load, n_ovl, n_resv;

  seq_mul_ctrl_if #(.W(W)) bus ();

  seq_mul_ctrl #(.W(W), .MAX_ITER(MAX_ITER)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .abort      (abort),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .loadA      (loadA),
    .loadB      (loadB),
    .decB       (decB),
    .loadF      (loadF),
    .clear      (clear),
    .zero       (zero),
    .dp_product (dp_product)
  );

  always #5 clk = ~clk;

  // Datapath: A register, B down-counter, accumulator.
  logic [W-1:0]   areg, bcnt;
  logic [2*W-1:0] acc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      areg <= '0; bcnt <= '0; acc <= '0;
    end else begin
      if (loadA) areg <= dp_a;
      if (loadB) bcnt <= dp_b;
      else if (decB) bcnt <= bcnt - 1'b1;
      if (clear) acc <= '0;
      else if (loadF) acc <= acc + {{W{1'b0}}, areg};
    end
  end
  assign zero       = force_zero_low ? 1'b0 : (bcnt == '0);
  assign dp_product = acc;

  // Strobe and result-valid activity counters.
  always @(negedge clk) begin
    if (decB) n_decb++;
    if (loadA || loadB) n_load++;
    if ((loadA || loadB) && decB) n_ovl++;
    if (bus.res_valid) n_resv++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    n_decb = 0; n_load = 0; n_ovl = 0; n_resv = 0;
  endtask

  // Edges after the accept edge until res_valid, bounded.
  task automatic wait_res(output int lat);
    lat = 0;
    while (!bus.res_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic handshake(input string tag);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    chk({tag, "_valid_drop"}, bus.res_valid, 0);
    chk({tag, "_ready_back"}, bus.req_ready, 1);
  endtask

  // One full transaction, expectations from the multiplication rules.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    mul_resp_t exp;
    int exp_lat, exp_dec, exp_load, lat;
    if (a == 0 || b == 0) begin
      exp.data = '0; exp.cycles = '0; exp.err = 1'b0;
      exp_lat = 0; exp_dec = 0; exp_load = 0;
    end else if (force_zero_low) begin
      exp.data = '0; exp.cycles = (W+1)'(MAX_ITER); exp.err = 1'b1;
      exp_lat = MAX_ITER + 1; exp_dec = MAX_ITER; exp_load = 1;
    end else begin
      exp.data = (2*W)'(int'(a) * int'(b)); exp.cycles = (W+1)'(b); exp.err = 1'b0;
      exp_lat = int'(b) + 3; exp_dec = int'(b); exp_load = 1;
    end
    clr_counts();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_a = a; bus.req_b = b;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_res(lat);
    chk($sformatf("lat_%0dx%0d", a, b), lat, exp_lat);
    chk($sformatf("data_%0dx%0d", a, b), bus.res_data, exp.data);
    chk($sformatf("cycles_%0dx%0d", a, b), bus.res_cycles, exp.cycles);
    chk($sformatf("err_%0dx%0d", a, b), bus.res_err, exp.err);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_data", bus.res_data, exp.data);
    end
    handshake("op");
    chk($sformatf("decb_%0dx%0d", a, b), n_decb, exp_dec);
    chk($sformatf("load_%0dx%0d", a, b), n_load, exp_load);
    chk("strobe_overlap", n_ovl, 0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; abort = 1'b0; force_zero_low = 1'b0;
    bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0; bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_cycles", bus.res_cycles, 0);
    chk("rst_res_err", bus.res_err, 0);
    chk("rst_clear", clear, 1);
    chk("rst_loadA", loadA, 0);
    chk("rst_decB", decB, 0);
    chk("rst_dp_a", dp_a, 0);
    rst_n = 1'b1;

    // Directed products and both zero-operand shortcuts.
    run_op(2'd3, 2'd2, 0);
    run_op(2'd3, 2'd3, 0);
    run_op(2'd2, 2'd1, 0);
    run_op(2'd0, 2'd3, 0);
    run_op(2'd3, 2'd0, 0);

    // Random operands and consumer stalls.
    repeat (24) run_op(W'($urandom_range(0, 3)), W'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    // Watchdog: counter never reaches zero.
    force_zero_low = 1'b1;
    run_op(2'd1, 2'd1, 0);
    force_zero_low = 1'b0;

    // Stalled consumer with a new request already waiting.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_a = 2'd3; bus.req_b = 2'd3;
    @(posedge clk); #1;
    bus.req_a = 2'd2; bus.req_b = 2'd1;
    wait_res(lat);
    chk("bp_lat", lat, 6);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_valid", bus.res_valid, 1);
      chk("bp_data", bus.res_data, 9);
      chk("bp_req_ready", bus.req_ready, 0);
    end
    handshake("bp");
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("bp_next_accepted", bus.req_ready, 0);
    wait_res(lat);
    chk("bp_next_data", bus.res_data, 2);
    chk("bp_next_cycles", bus.res_cycles, 1);
    handshake("bp_next");

    // Reset during the second ADD cycle.
    clr_counts();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_a = 2'd3; bus.req_b = 2'd3;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_req_ready", bus.req_ready, 1);
    chk("mrst_res_valid", bus.res_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("mrst_no_result", n_resv, 0);
    run_op(2'd2, 2'd2, 0);

    // Abort in the first ADD cycle.
    clr_counts();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_a = 2'd3; bus.req_b = 2'd3;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_req_ready", bus.req_ready, 1);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_result", n_resv, 0);
    run_op(2'd2, 2'd2, 0);

    // Abort while a result is waiting is ignored.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_a = 2'd1; bus.req_b = 2'd1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    wait_res(lat);
    abort = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("done_abort_valid", bus.res_valid, 1);
      chk("done_abort_data", bus.res_data, 1);
    end
    abort = 1'b0;
    handshake("done_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
